// File: rtl/shift_reg.sv
// Parameterised delay line: STAGE registers of WIDTH bits, async reset.
// STAGE = 0 degenerates to a plain wire from din to dout.
module shift_reg #(
  parameter int WIDTH = 8,
  parameter int STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
      $error("shift_reg: WIDTH must be in 1..1024");
    end else if (STAGE < 0 || STAGE > 256) begin : g_bad_stage
      $error("shift_reg: STAGE must be in 0..256");
    end else if (STAGE == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [STAGE];
      logic [WIDTH-1:0] stage_d [STAGE];

      always_comb begin
        stage_d[0] = din;
        for (int k = 1; k < STAGE; k++) begin
          stage_d[k] = stage_q[k-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < STAGE; k++) begin
            stage_q[k] <= '0;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      // Output straight from the last flop, no logic after it.
      assign dout = stage_q[STAGE-1];
    end
  endgenerate

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg across several WIDTH/STAGE configs.
// History-queue model plus directed literal expectations.
module tb_shift_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  d2 = '0, q2o;
  logic [7:0]  d0 = '0, q0o;
  logic [7:0]  d1 = '0, q1o;
  logic [7:0]  d5 = '0, q5o;
  logic        dw1 = 1'b0, qw1o;
  logic [63:0] dw64 = '0, qw64o;

  shift_reg #(.WIDTH(8), .STAGE(2)) u_s2 (
    .clk(clk), .rst(rst), .din(d2), .dout(q2o));
  shift_reg #(.WIDTH(8), .STAGE(0)) u_s0 (
    .clk(clk), .rst(rst), .din(d0), .dout(q0o));
  shift_reg #(.WIDTH(8), .STAGE(1)) u_s1 (
    .clk(clk), .rst(rst), .din(d1), .dout(q1o));
  shift_reg #(.WIDTH(8), .STAGE(5)) u_s5 (
    .clk(clk), .rst(rst), .din(d5), .dout(q5o));
  shift_reg #(.WIDTH(1), .STAGE(3)) u_w1 (
    .clk(clk), .rst(rst), .din(dw1), .dout(qw1o));
  shift_reg #(.WIDTH(64), .STAGE(2)) u_w64 (
    .clk(clk), .rst(rst), .din(dw64), .dout(qw64o));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Samples taken since the last reset, oldest first.
  logic [63:0] h2[$], h1[$], h5[$], hw1[$], hw64[$];
  logic [63:0] junk;

  function automatic logic [63:0] delayed(input logic [63:0] h[$],
                                          input int s);
    if (h.size() < s) return '0;
    return h[h.size()-s];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h2.delete(); h1.delete(); h5.delete();
      hw1.delete(); hw64.delete();
    end else begin
      h2.push_back({56'b0, d2});
      h1.push_back({56'b0, d1});
      h5.push_back({56'b0, d5});
      hw1.push_back({63'b0, dw1});
      hw64.push_back(dw64);
      if (h2.size() > 8) junk = h2.pop_front();
      if (h1.size() > 8) junk = h1.pop_front();
      if (h5.size() > 8) junk = h5.pop_front();
      if (hw1.size() > 8) junk = hw1.pop_front();
      if (hw64.size() > 8) junk = hw64.pop_front();
    end
  end

  always @(negedge clk) begin
    chk("m_s2", {56'b0, q2o}, delayed(h2, 2));
    chk("m_s0", {56'b0, q0o}, {56'b0, d0});
    chk("m_s1", {56'b0, q1o}, delayed(h1, 1));
    chk("m_s5", {56'b0, q5o}, delayed(h5, 5));
    chk("m_w1", {63'b0, qw1o}, delayed(hw1, 3));
    chk("m_w64", qw64o, delayed(hw64, 2));
  end

  task automatic drive_others();
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    d5 = 8'($urandom);
    dw1 = ~dw1;
    dw64 = ~dw64;
  endtask

  logic [7:0] seq [6] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'hA5, 8'h5A};
  logic [7:0] wexp[6] = '{8'h00, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'hA5};
  logic [7:0] rexp[3] = '{8'h00, 8'h11, 8'h22};

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_s2", {56'b0, q2o}, 64'h0);
    chk("reset_w64", qw64o, 64'h0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Incrementing din from 0.
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) chk("inc_e1", {56'b0, q2o}, 64'h0);
      if (e == 2) chk("inc_e2", {56'b0, q2o}, 64'h0);
      if (e == 3) chk("inc_e3", {56'b0, q2o}, 64'h1);
      if (e == 5) chk("inc_e5", {56'b0, q2o}, 64'h3);
      d2 = 8'(e);
      drive_others();
    end

    // Wrap-around sequence straight after a reset.
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    d2 = seq[0];
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("wrap", {56'b0, q2o}, {56'b0, wexp[i]});
      if (i < 5) d2 = seq[i+1];
      drive_others();
    end

    // Pipeline holds 5A/A5; reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_s2", {56'b0, q2o}, 64'h0);
    chk("async_rst_s5", {56'b0, q5o}, 64'h0);
    d0 = 8'h3C;
    #1;
    chk("s0_in_rst", {56'b0, q0o}, 64'h3C);
    d2 = 8'h77;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold", {56'b0, q2o}, 64'h0);
      drive_others();
    end
    d2 = 8'h11;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst", {56'b0, q2o}, {56'b0, rexp[i]});
      d2 = (i == 0) ? 8'h22 : 8'h33;
      drive_others();
    end

    // Random traffic, checked by the model every cycle.
    repeat (40) begin
      @(posedge clk);
      #1;
      d2 = 8'($urandom);
      drive_others();
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
